// File: rtl/pixel_rotate_map_pkg.sv
// Shared definitions for the rotating pixel-address generator: FIFO entry
// flag layout, identity coefficient constants and elaboration helpers.
package pixel_rotate_map_pkg;

    // Each FIFO entry is {flags, address}; flags sit above the address bits.
    typedef struct packed {
        logic valid;
        logic sof;
    } entry_flags_t;

    localparam int unsigned ENTRY_FLAG_W = $bits(entry_flags_t);
    localparam int          IDENTITY_SIN = 0;

    function automatic int identity_cos(input int frac);
        return 1 << frac;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pixel_addr_fifo.sv
// Synchronous show-ahead FIFO: the head entry is presented combinationally
// and reads as zero while the FIFO is empty.
module pixel_addr_fifo
    import pixel_rotate_map_pkg::*;
#(
    parameter int W     = 22,
    parameter int DEPTH = 16
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       iPUSH,
    input  logic [W-1:0]               iDATA,
    input  logic                       iPOP,
    output logic [W-1:0]               oDATA,
    output logic                       oEMPTY,
    output logic [$clog2(DEPTH):0]     oCOUNT
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             empty;
    logic             push;
    logic             pop;

    always_comb begin
        empty = (count == '0);
        pop   = iPOP && !empty;
        push  = iPUSH && ((count != (PTR_W+1)'(DEPTH)) || pop);
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= iDATA;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        oDATA  = empty ? '0 : mem[rd_ptr];
        oEMPTY = empty;
        oCOUNT = count;
    end

endmodule

// File: rtl/pixel_rotate_map.sv
// Raster walker with fixed-point rotation about (CX,CY), range check and
// vertically flipped linear address, buffered in a credit-controlled FIFO.
module pixel_rotate_map
    import pixel_rotate_map_pkg::*;
#(
    parameter int WIDTH  = 800,
    parameter int HEIGHT = 480,
    parameter int CX     = 400,
    parameter int CY     = 240,
    parameter int COEF_W = 10,
    parameter int FRAC   = 8,
    parameter int ADDR_W = 20,
    parameter int DEPTH  = 16
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic signed [COEF_W-1:0] iSIN,
    input  logic signed [COEF_W-1:0] iCOS,
    input  logic                     iBYPASS,
    input  logic                     iCOEF_LOAD,
    input  logic                     iREAD,
    output logic [ADDR_W-1:0]        oADDRESS,
    output logic                     oADDR_VALID,
    output logic                     oSOF,
    output logic                     oREADY_N
);

    localparam int CNT_W  = $clog2(max2(WIDTH, HEIGHT));
    localparam int DW     = CNT_W + 1;
    localparam int PW     = DW + COEF_W;
    localparam int EW     = max2(PW + 3, ADDR_W + 2);
    localparam int ENT_W  = ADDR_W + ENTRY_FLAG_W;
    localparam int CNTF_W = $clog2(DEPTH) + 1;

    typedef logic signed [COEF_W-1:0] coef_t;
    localparam coef_t COS_ONE  = coef_t'(identity_cos(FRAC));
    localparam coef_t SIN_ZERO = coef_t'(IDENTITY_SIN);

    logic [CNT_W-1:0]  col, row;
    logic [CNTF_W-1:0] fifo_count;
    logic [1:0]        in_flight;
    logic              issue, is_origin;

    coef_t sh_cos, sh_sin, act_cos, act_sin, sel_cos, sel_sin;
    logic  sh_byp, act_byp, sel_byp;

    logic                 s1_v, s1_sof, s1_byp;
    logic signed [DW-1:0] s1_dx, s1_dy;
    coef_t                s1_cos, s1_sin;

    logic                 s2_v, s2_sof, s2_byp;
    logic signed [DW-1:0] s2_dx, s2_dy;
    logic signed [PW-1:0] s2_dxc, s2_dys, s2_dxs, s2_dyc;

    logic signed [EW-1:0] rx, ry, x, y, lin;
    logic                 in_rng;
    logic [ADDR_W-1:0]    st3_addr;

    logic                 s3_v;
    logic [ENT_W-1:0]     s3_entry, fifo_head;
    logic                 fifo_empty;
    entry_flags_t         head_flags;

    always_comb begin
        in_flight = 2'(s1_v) + 2'(s2_v) + 2'(s3_v);
        issue     = (int'(fifo_count) + int'(in_flight)) < DEPTH;
        is_origin = (col == '0) && (row == '0);
        // The origin pixel must see the shadow values being promoted this cycle.
        sel_cos   = is_origin ? sh_cos : act_cos;
        sel_sin   = is_origin ? sh_sin : act_sin;
        sel_byp   = is_origin ? sh_byp : act_byp;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            col <= '0;
            row <= '0;
        end else if (issue) begin
            if (col == CNT_W'(WIDTH - 1)) begin
                col <= '0;
                row <= (row == CNT_W'(HEIGHT - 1)) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sh_cos  <= COS_ONE;
            sh_sin  <= SIN_ZERO;
            sh_byp  <= 1'b0;
            act_cos <= COS_ONE;
            act_sin <= SIN_ZERO;
            act_byp <= 1'b0;
        end else begin
            if (iCOEF_LOAD) begin
                sh_cos <= iCOS;
                sh_sin <= iSIN;
                sh_byp <= iBYPASS;
            end
            if (issue && is_origin) begin
                act_cos <= sh_cos;
                act_sin <= sh_sin;
                act_byp <= sh_byp;
            end
        end
    end

    // Coefficients travel with each pixel so a frame boundary inside the
    // pipeline never mixes two angles.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1_v   <= 1'b0;
            s1_sof <= 1'b0;
            s1_byp <= 1'b0;
            s1_dx  <= '0;
            s1_dy  <= '0;
            s1_cos <= '0;
            s1_sin <= '0;
            s2_v   <= 1'b0;
            s2_sof <= 1'b0;
            s2_byp <= 1'b0;
            s2_dx  <= '0;
            s2_dy  <= '0;
            s2_dxc <= '0;
            s2_dys <= '0;
            s2_dxs <= '0;
            s2_dyc <= '0;
            s3_v     <= 1'b0;
            s3_entry <= '0;
        end else begin
            s1_v   <= issue;
            s1_sof <= issue && is_origin;
            s1_byp <= sel_byp;
            s1_dx  <= DW'(col) - DW'(CX);
            s1_dy  <= DW'(row) - DW'(CY);
            s1_cos <= sel_cos;
            s1_sin <= sel_sin;

            s2_v   <= s1_v;
            s2_sof <= s1_sof;
            s2_byp <= s1_byp;
            s2_dx  <= s1_dx;
            s2_dy  <= s1_dy;
            s2_dxc <= PW'(s1_dx) * PW'(s1_cos);
            s2_dys <= PW'(s1_dy) * PW'(s1_sin);
            s2_dxs <= PW'(s1_dx) * PW'(s1_sin);
            s2_dyc <= PW'(s1_dy) * PW'(s1_cos);

            s3_v     <= s2_v;
            s3_entry <= {in_rng, s2_sof, st3_addr};
        end
    end

    always_comb begin
        rx = EW'(s2_dxc) - EW'(s2_dys);
        ry = EW'(s2_dxs) + EW'(s2_dyc);
        if (s2_byp) begin
            x = EW'(s2_dx) + EW'(CX);
            y = EW'(s2_dy) + EW'(CY);
        end else begin
            x = (rx >>> FRAC) + EW'(CX);
            y = (ry >>> FRAC) + EW'(CY);
        end
        in_rng   = !x[EW-1] && (x < EW'(WIDTH)) && !y[EW-1] && (y < EW'(HEIGHT));
        lin      = (EW'(HEIGHT - 1) - y) * EW'(WIDTH) + x;
        st3_addr = in_rng ? ADDR_W'(lin) : '0;
    end

    pixel_addr_fifo #(
        .W     (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK    (CLK),
        .RESET  (RESET),
        .iPUSH  (s3_v),
        .iDATA  (s3_entry),
        .iPOP   (iREAD),
        .oDATA  (fifo_head),
        .oEMPTY (fifo_empty),
        .oCOUNT (fifo_count)
    );

    always_comb begin
        {head_flags, oADDRESS} = fifo_head;
        oADDR_VALID = head_flags.valid;
        oSOF        = head_flags.sof;
        oREADY_N    = fifo_empty;
    end

endmodule

// File: tb/tb_pixel_rotate_map.sv
// Directed bench for pixel_rotate_map on a 16x8 display centred at (8,4).
module tb_pixel_rotate_map;

    localparam int TW      = 16;
    localparam int TH      = 8;
    localparam int TCX     = 8;
    localparam int TCY     = 4;
    localparam int TCOEF_W = 10;
    localparam int TFRAC   = 8;
    localparam int TADDR_W = 8;
    localparam int TDEPTH  = 16;
    localparam int FRAME   = TW * TH;

    logic                      CLK;
    logic                      RESET;
    logic signed [TCOEF_W-1:0] iSIN;
    logic signed [TCOEF_W-1:0] iCOS;
    logic                      iBYPASS;
    logic                      iCOEF_LOAD;
    logic                      iREAD;
    logic [TADDR_W-1:0]        oADDRESS;
    logic                      oADDR_VALID;
    logic                      oSOF;
    logic                      oREADY_N;

    int errors = 0;
    int checks = 0;
    int pix    = 0;

    pixel_rotate_map #(
        .WIDTH  (TW),
        .HEIGHT (TH),
        .CX     (TCX),
        .CY     (TCY),
        .COEF_W (TCOEF_W),
        .FRAC   (TFRAC),
        .ADDR_W (TADDR_W),
        .DEPTH  (TDEPTH)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .iSIN        (iSIN),
        .iCOS        (iCOS),
        .iBYPASS     (iBYPASS),
        .iCOEF_LOAD  (iCOEF_LOAD),
        .iREAD       (iREAD),
        .oADDRESS    (oADDRESS),
        .oADDR_VALID (oADDR_VALID),
        .oSOF        (oSOF),
        .oREADY_N    (oREADY_N)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected {valid, sof, address} for raster position p of a frame.
    function automatic logic [9:0] model(input int p, input int cs, input int sn, input bit byp);
        int c = p % TW;
        int r = p / TW;
        int dx = c - TCX;
        int dy = r - TCY;
        int x, y;
        logic v;
        logic [7:0] a;
        if (byp) begin
            x = c;
            y = r;
        end else begin
            x = ((dx * cs - dy * sn) >>> TFRAC) + TCX;
            y = ((dx * sn + dy * cs) >>> TFRAC) + TCY;
        end
        v = (x >= 0) && (x < TW) && (y >= 0) && (y < TH);
        a = v ? 8'((TH - 1 - y) * TW + x) : 8'd0;
        return {v, (p == 0), a};
    endfunction

    task automatic read_pixels(input int n, input int cs, input int sn, input bit byp);
        iREAD = 1'b1;
        for (int k = 0; k < n; k++) begin
            check($sformatf("ready_p%0d", pix), 32'(oREADY_N), 32'd0);
            check($sformatf("entry_p%0d", pix), 32'({oADDR_VALID, oSOF, oADDRESS}),
                  32'(model(pix, cs, sn, byp)));
            step();
            pix = (pix + 1) % FRAME;
        end
        iREAD = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [9:0] exp);
        for (int t = 0; t < 64 && oREADY_N; t++) step();
        check({tag, "_ready"}, 32'(oREADY_N), 32'd0);
        check(tag, 32'({oADDR_VALID, oSOF, oADDRESS}), 32'(exp));
    endtask

    task automatic load(input int cs, input int sn, input bit byp);
        iCOS       = TCOEF_W'(cs);
        iSIN       = TCOEF_W'(sn);
        iBYPASS    = byp;
        iCOEF_LOAD = 1'b1;
        step();
        iCOEF_LOAD = 1'b0;
    endtask

    initial begin
        RESET      = 1'b1;
        iSIN       = '0;
        iCOS       = '0;
        iBYPASS    = 1'b0;
        iCOEF_LOAD = 1'b0;
        iREAD      = 1'b0;
        step();
        step();
        check("rst_ready_n", 32'(oREADY_N), 32'd1);
        check("rst_address", 32'(oADDRESS), 32'd0);
        check("rst_valid", 32'(oADDR_VALID), 32'd0);
        check("rst_sof", 32'(oSOF), 32'd0);

        RESET = 1'b0;
        step();
        step();
        step();
        check("latency_3", 32'(oREADY_N), 32'd1);
        step();
        check("latency_4", 32'(oREADY_N), 32'd0);

        pix = 0;
        check_head("first", {1'b1, 1'b1, 8'd112});
        read_pixels(16, 256, 0, 0);
        check_head("row1", {1'b1, 1'b0, 8'd96});
        read_pixels(112, 256, 0, 0);

        check_head("frame1_sof", {1'b1, 1'b1, 8'd112});
        read_pixels(20, 256, 0, 0);
        load(-256, 0, 0);
        read_pixels(108, 256, 0, 0);

        check_head("r180_origin", {1'b0, 1'b1, 8'd0});
        read_pixels(17, -256, 0, 0);
        check_head("r180_p11", {1'b1, 1'b0, 8'd15});
        read_pixels(13, -256, 0, 0);
        load(100, 50, 0);
        load(0, 256, 0);
        read_pixels(98, -256, 0, 0);

        check_head("r90_origin", {1'b0, 1'b1, 8'd0});
        read_pixels(72, 0, 256, 0);
        check_head("r90_centre", {1'b1, 1'b0, 8'd56});
        read_pixels(28, 0, 256, 0);
        load(123, -77, 1);
        read_pixels(28, 0, 256, 0);

        check_head("byp_origin", {1'b1, 1'b1, 8'd112});
        read_pixels(10, 123, -77, 1);
        repeat (50) step();
        check("hold_count50", 32'(dut.fifo_count), 32'(TDEPTH));
        repeat (50) step();
        check("hold_count100", 32'(dut.fifo_count), 32'(TDEPTH));
        check_head("hold_head", {1'b1, 1'b0, 8'd122});
        read_pixels(118, 123, -77, 1);

        read_pixels(40, 123, -77, 1);
        load(-256, 0, 0);
        RESET = 1'b1;
        #1;
        check("midrst_ready_n", 32'(oREADY_N), 32'd1);
        check("midrst_head", 32'({oADDR_VALID, oSOF, oADDRESS}), 32'd0);
        step();
        RESET = 1'b0;
        pix = 0;
        check_head("post_rst", {1'b1, 1'b1, 8'd112});
        read_pixels(128, 256, 0, 0);
        check_head("post_rst_frame2", {1'b1, 1'b1, 8'd112});
        read_pixels(20, 256, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
